// File: rtl/debug_halt_group_pkg.sv
// -----------------------------------------------------------------------------
// debug_halt_group_pkg
// Shared declarations for the debug halt-group controller.
//   halt_grp_state_e : controller state (IDLE, WAIT_ACK, HALTED)
// -----------------------------------------------------------------------------
package debug_halt_group_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      HALTED   = 2'd2
   } halt_grp_state_e;

endpackage

// File: rtl/debug_halt_group_if.sv
// -----------------------------------------------------------------------------
// debug_halt_group_if
// Bundles the signals running between the debug subsystem, the halt-group
// controller and the cores.
//   clk_i            : clock shared by everything on the bundle
//   debug_req        : per-hart halt request from the debug subsystem
//   ndmreset_n       : non-debug-module reset, active-low
//   group_en         : 1 = halting any hart halts all available harts
//   hart_unavailable : per-hart exclusion from the target mask
//   debug_mode       : per-hart "in debug mode" status from the cores
//   core_req         : registered per-hart debug request to the cores
//   halt_done        : pulse, all targeted harts are halted
//   timeout          : pulse, halt attempt abandoned
// master = debug subsystem / core side, slave = halt-group controller side.
// -----------------------------------------------------------------------------
interface debug_halt_group_if #(
   parameter int unsigned NrHarts = 2
) (
   input logic clk_i
);

   logic [NrHarts-1:0] debug_req;
   logic               ndmreset_n;
   logic               group_en;
   logic [NrHarts-1:0] hart_unavailable;
   logic [NrHarts-1:0] debug_mode;
   logic [NrHarts-1:0] core_req;
   logic               halt_done;
   logic               timeout;

   modport master (
      input  clk_i,
      output debug_req, ndmreset_n, group_en, hart_unavailable, debug_mode,
      input  core_req, halt_done, timeout
   );

   modport slave (
      input  clk_i,
      input  debug_req, ndmreset_n, group_en, hart_unavailable, debug_mode,
      output core_req, halt_done, timeout
   );

endinterface

// File: rtl/debug_halt_group.sv
// -----------------------------------------------------------------------------
// debug_halt_group
// Sits between the debug subsystem's per-hart halt requests and the cores'
// debug request inputs. A request to any available hart captures a target
// mask (the requested harts, or every available hart when grouping is on),
// drives requests until each targeted hart reports debug mode, and then holds
// off until all targeted harts have resumed. A halt that is not fully
// acknowledged within TimeoutCycles cycles is abandoned.
//
// Ports
//   clk_i              : clock
//   rst_ni             : asynchronous reset, active-low
//   debug_req_i        : [NrHarts] halt request from the debug subsystem
//   debug_ndmreset_ni  : non-debug-module reset, active-low, synchronous
//   group_en_i         : 1 = halt all available harts together
//   hart_unavailable_i : [NrHarts] 1 = hart never targeted
//   debug_mode_i       : [NrHarts] hart is in debug mode
//   debug_req_o        : [NrHarts] registered debug request to the cores
//   halt_done_o        : one-cycle pulse, all targeted harts halted
//   timeout_o          : one-cycle pulse, halt abandoned after timeout
// -----------------------------------------------------------------------------
module debug_halt_group
   import debug_halt_group_pkg::*;
#(
   parameter int unsigned NrHarts       = 2,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NrHarts-1:0] debug_req_i,
   input  logic               debug_ndmreset_ni,
   input  logic               group_en_i,
   input  logic [NrHarts-1:0] hart_unavailable_i,
   input  logic [NrHarts-1:0] debug_mode_i,
   output logic [NrHarts-1:0] debug_req_o,
   output logic               halt_done_o,
   output logic               timeout_o
);

   localparam int unsigned    CntW    = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   halt_grp_state_e    r_state, w_state_nxt;
   logic [NrHarts-1:0] r_mask, w_mask_nxt;
   logic [NrHarts-1:0] r_req, w_req_nxt;
   logic [CntW-1:0]    r_cnt, w_cnt_nxt;
   logic               r_done, w_done_nxt;
   logic               r_to, w_to_nxt;
   logic [NrHarts-1:0] w_live;
   logic               w_all_ack;
   logic               w_none_ack;

   always_comb begin
      w_live      = debug_req_i & ~hart_unavailable_i;
      w_all_ack   = (debug_mode_i & r_mask) == r_mask;
      w_none_ack  = (debug_mode_i & r_mask) == '0;
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_cnt_nxt   = r_cnt;
      w_req_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_to_nxt    = 1'b0;

      if (!debug_ndmreset_ni) begin
         w_state_nxt = IDLE;
         w_mask_nxt  = '0;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               // Requests aimed only at unavailable harts leave w_live empty.
               if (|w_live) begin
                  w_mask_nxt  = group_en_i ? ~hart_unavailable_i : w_live;
                  w_req_nxt   = w_mask_nxt;
                  w_cnt_nxt   = '0;
                  w_state_nxt = WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               w_cnt_nxt = r_cnt + 1'b1;
               // Full acknowledge is tested first so it wins over a
               // simultaneous timeout.
               if (w_all_ack) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = HALTED;
               end else if (r_cnt == CntLast) begin
                  w_to_nxt    = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_req_nxt = r_mask & ~debug_mode_i;
               end
            end
            HALTED: begin
               if (w_none_ack) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_cnt   <= '0;
         r_req   <= '0;
         r_done  <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req   <= w_req_nxt;
         r_done  <= w_done_nxt;
         r_to    <= w_to_nxt;
      end
   end

   assign debug_req_o = r_req;
   assign halt_done_o = r_done;
   assign timeout_o   = r_to;

endmodule

// File: tb/tb_debug_halt_group.sv
module tb_debug_halt_group;

   localparam int NH = 2;
   localparam int TO = 8;

   localparam logic [1:0] M_IDLE = 2'd0;
   localparam logic [1:0] M_WAIT = 2'd1;
   localparam logic [1:0] M_HALT = 2'd2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   debug_halt_group_if #(.NrHarts(NH)) bus (.clk_i(clk));

   debug_halt_group #(.NrHarts(NH), .TimeoutCycles(TO)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .debug_req_i        (bus.debug_req),
      .debug_ndmreset_ni  (bus.ndmreset_n),
      .group_en_i         (bus.group_en),
      .hart_unavailable_i (bus.hart_unavailable),
      .debug_mode_i       (bus.debug_mode),
      .debug_req_o        (bus.core_req),
      .halt_done_o        (bus.halt_done),
      .timeout_o          (bus.timeout)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural reference: a halt attempt counts the cycles it has spent
   // waiting (1 on entry) and gives up once it has waited TO cycles.
   typedef struct packed {
      logic [1:0]    mode;
      logic [NH-1:0] mask;
      logic [15:0]   waited;
      logic [NH-1:0] req;
      logic          done;
      logic          to;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t model_step(input mdl_t s, input logic [NH-1:0] dreq,
                                       input logic ndm, input logic gen,
                                       input logic [NH-1:0] unav,
                                       input logic [NH-1:0] dmode);
      mdl_t n;
      logic [NH-1:0] live;
      n      = s;
      n.done = 1'b0;
      n.to   = 1'b0;
      n.req  = '0;
      live   = dreq & ~unav;
      if (!ndm) begin
         n = '0;
      end else if (s.mode == M_IDLE) begin
         if (live != '0) begin
            n.mask   = gen ? ~unav : live;
            n.mode   = M_WAIT;
            n.waited = 16'd1;
            n.req    = n.mask;
         end
      end else if (s.mode == M_WAIT) begin
         if ((dmode & s.mask) == s.mask) begin
            n.done = 1'b1;
            n.mode = M_HALT;
         end else if (s.waited == 16'(TO)) begin
            n.to   = 1'b1;
            n.mode = M_IDLE;
         end else begin
            n.waited = s.waited + 16'd1;
            n.req    = s.mask & ~dmode;
         end
      end else begin
         if ((dmode & s.mask) == '0) n.mode = M_IDLE;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else m <= model_step(m, bus.debug_req, bus.ndmreset_n, bus.group_en,
                           bus.hart_unavailable, bus.debug_mode);
   end

   // Every cycle: DUT outputs against the model.
   always @(negedge clk) begin
      check("mdl_req_o", 32'(bus.core_req), 32'(m.req));
      check("mdl_halt_done", 32'(bus.halt_done), 32'(m.done));
      check("mdl_timeout", 32'(bus.timeout), 32'(m.to));
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.debug_req        = '0;
      bus.ndmreset_n       = 1'b1;
      bus.group_en         = 1'b0;
      bus.hart_unavailable = '0;
      bus.debug_mode       = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      bus.debug_req  = 2'b11;
      bus.debug_mode = 2'b11;
      repeat (2) @(negedge clk);
      check("rst_req_o", 32'(bus.core_req), 32'h0);
      check("rst_halt_done", 32'(bus.halt_done), 32'h0);
      check("rst_timeout", 32'(bus.timeout), 32'h0);
      idle_inputs();
      rst_n = 1'b1;
      step();

      // Single hart, acknowledged three cycles after the request.
      bus.debug_req = 2'b01;
      step();
      check("s1_req_c1", 32'(bus.core_req), 32'h1);
      bus.debug_req = 2'b00;
      step();
      check("s1_req_c2", 32'(bus.core_req), 32'h1);
      step();
      check("s1_req_c3", 32'(bus.core_req), 32'h1);
      bus.debug_mode = 2'b01;
      step();
      check("s1_done", 32'(bus.halt_done), 32'h1);
      check("s1_req_off", 32'(bus.core_req), 32'h0);
      step();
      check("s1_done_once", 32'(bus.halt_done), 32'h0);
      check("s1_req_halted", 32'(bus.core_req), 32'h0);
      bus.debug_mode = 2'b00;
      repeat (2) step();

      // Group halt, harts acknowledging one after the other.
      bus.group_en  = 1'b1;
      bus.debug_req = 2'b10;
      step();
      check("grp_req_11", 32'(bus.core_req), 32'h3);
      bus.debug_req  = 2'b00;
      bus.debug_mode = 2'b10;
      step();
      check("grp_req_01", 32'(bus.core_req), 32'h1);
      check("grp_not_done", 32'(bus.halt_done), 32'h0);
      bus.debug_mode = 2'b11;
      step();
      check("grp_req_00", 32'(bus.core_req), 32'h0);
      check("grp_done", 32'(bus.halt_done), 32'h1);
      bus.debug_mode = 2'b00;
      bus.group_en   = 1'b0;
      repeat (2) step();

      // No acknowledge: timeout eight cycles after entry.
      bus.debug_req = 2'b01;
      step();
      bus.debug_req = 2'b00;
      for (int k = 1; k < TO; k++) begin
         step();
         check("to_early", 32'(bus.timeout), 32'h0);
         check("to_req_held", 32'(bus.core_req), 32'h1);
      end
      step();
      check("to_pulse", 32'(bus.timeout), 32'h1);
      check("to_req_off", 32'(bus.core_req), 32'h0);
      step();
      check("to_once", 32'(bus.timeout), 32'h0);
      check("to_req_idle", 32'(bus.core_req), 32'h0);

      // Unavailable hart excluded; mask frozen after capture.
      bus.hart_unavailable = 2'b10;
      bus.group_en         = 1'b1;
      bus.debug_req        = 2'b10;
      step();
      check("unav_ignored", 32'(bus.core_req), 32'h0);
      step();
      check("unav_ignored2", 32'(bus.core_req), 32'h0);
      bus.debug_req = 2'b11;
      step();
      check("unav_mask01", 32'(bus.core_req), 32'h1);
      bus.debug_req        = 2'b00;
      bus.hart_unavailable = 2'b00;
      step();
      check("mask_frozen", 32'(bus.core_req), 32'h1);
      bus.debug_mode = 2'b01;
      step();
      check("unav_done", 32'(bus.halt_done), 32'h1);
      idle_inputs();
      repeat (2) step();

      // Non-debug-module reset in the middle of a halt attempt.
      bus.debug_req = 2'b01;
      step();
      bus.debug_req = 2'b00;
      step();
      check("ndm_pre", 32'(bus.core_req), 32'h1);
      bus.ndmreset_n = 1'b0;
      step();
      check("ndm_req_off", 32'(bus.core_req), 32'h0);
      check("ndm_no_done", 32'(bus.halt_done), 32'h0);
      check("ndm_no_to", 32'(bus.timeout), 32'h0);
      bus.ndmreset_n = 1'b1;
      for (int k = 0; k < TO + 2; k++) begin
         step();
         check("ndm_idle_to", 32'(bus.timeout), 32'h0);
         check("ndm_idle_req", 32'(bus.core_req), 32'h0);
      end
      bus.debug_req = 2'b10;
      step();
      check("ndm_new_req", 32'(bus.core_req), 32'h2);
      bus.debug_req  = 2'b00;
      bus.debug_mode = 2'b10;
      step();
      check("ndm_new_done", 32'(bus.halt_done), 32'h1);
      idle_inputs();
      repeat (2) step();

      // Final acknowledge lands in the timeout cycle.
      bus.debug_req = 2'b01;
      step();
      bus.debug_req = 2'b00;
      repeat (TO - 1) step();
      bus.debug_mode = 2'b01;
      step();
      check("race_done", 32'(bus.halt_done), 32'h1);
      check("race_no_to", 32'(bus.timeout), 32'h0);
      idle_inputs();
      repeat (2) step();

      // Random traffic checked by the model on every cycle.
      for (int i = 0; i < 3000; i++) begin
         bus.debug_req        = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0;
         bus.group_en         = 1'($urandom_range(0, 1));
         bus.hart_unavailable = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0;
         if ($urandom_range(0, 2) == 0) bus.debug_mode = NH'($urandom);
         bus.ndmreset_n       = ($urandom_range(0, 49) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/debug_halt_group.md
DEBUG_HALT_GROUP -- requirements
Module: debug_halt_group

Interface
REQ-001 SHALL have parameter NrHarts, default 2, number of harts served by the debug module.
REQ-002 SHALL have parameter TimeoutCycles, default 1024, maximum number of WAIT_ACK cycles before abort.
REQ-003 SHALL have port clk_i  input  1  clock; one clock domain only.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port debug_req_i  input  NrHarts  per-hart halt request from the debug subsystem (debug_core_req_o).
REQ-006 SHALL have port debug_ndmreset_ni  input  1  non-debug-module reset from the debug subsystem, active-low.
REQ-007 SHALL have port group_en_i  input  1  1 = halting any hart halts all available harts.
REQ-008 SHALL have port hart_unavailable_i  input  NrHarts  1 = hart excluded from any target mask.
REQ-009 SHALL have port debug_mode_i  input  NrHarts  per-hart "in debug mode" status from the cores.
REQ-010 SHALL have port debug_req_o  output  NrHarts  registered per-hart debug request to the cores.
REQ-011 SHALL have port halt_done_o  output  1  one-cycle pulse when all targeted harts are in debug mode.
REQ-012 SHALL have port timeout_o  output  1  one-cycle pulse when WAIT_ACK is aborted by timeout.

Function
REQ-013 SHALL implement an FSM with the states IDLE, WAIT_ACK and HALTED.
REQ-014 In IDLE, if (debug_req_i & ~hart_unavailable_i) != 0, the block SHALL capture mask = group_en_i ? ~hart_unavailable_i : (debug_req_i & ~hart_unavailable_i), clear the counter and enter WAIT_ACK.
REQ-015 In IDLE, requests that target only unavailable harts SHALL be ignored.
REQ-016 In WAIT_ACK, the next value of debug_req_o SHALL be mask & ~debug_mode_i, so each hart's request drops one cycle after that hart acknowledges.
REQ-017 The first assertion of debug_req_o SHALL occur exactly 1 cycle after debug_req_i is sampled in IDLE (the IDLE-to-WAIT_ACK transition).
REQ-018 In WAIT_ACK, when (debug_mode_i & mask) == mask, the block SHALL pulse halt_done_o for 1 cycle, enter HALTED and drive debug_req_o to 0 on the next cycle.
REQ-019 The counter SHALL have width $clog2(TimeoutCycles+1) and SHALL increment once per WAIT_ACK cycle.
REQ-020 When the counter reaches TimeoutCycles-1 without a full acknowledge, the block SHALL pulse timeout_o, zero debug_req_o and return to IDLE.
REQ-021 If the full acknowledge and the timeout occur in the same cycle, the acknowledge SHALL win: halt_done_o pulses and timeout_o does not.
REQ-022 In HALTED, debug_req_o SHALL be 0 and debug_req_i SHALL be ignored.
REQ-023 The block SHALL leave HALTED for IDLE when (debug_mode_i & mask) == 0, i.e. all targeted harts have resumed.
REQ-024 Changes on group_en_i or hart_unavailable_i after the mask is captured SHALL NOT alter the mask.
REQ-025 debug_ndmreset_ni low SHALL synchronously force IDLE, zero debug_req_o, zero the mask and zero the counter, with no pulse on halt_done_o or timeout_o.
REQ-026 All outputs SHALL be driven from flops; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 On rst_ni low, the block SHALL asynchronously set state = IDLE, mask = 0, counter = 0, debug_req_o = 0, halt_done_o = 0 and timeout_o = 0.
REQ-028 On rst_ni high, the block SHALL begin operating on the first clk_i rising edge; there SHALL be no reset synchronizer inside the block.

Structure
REQ-029 The FSM state enum (halt_grp_state_e) SHALL be defined in a shared package, debug_halt_group_pkg.
REQ-030 The block SHALL be a single module with no sub-modules.
REQ-031 The block SHALL sit between debug_core_req_o of the debug subsystem and the cores' debug_req_i.

Verification
REQ-032 With NrHarts=2, group_en_i=0, pulse debug_req_i=01, then debug_mode_i=01 three cycles later: debug_req_o SHALL be 01 for cycles 1-3, halt_done_o SHALL pulse once and debug_req_o SHALL be 0 afterward.
REQ-033 With group_en_i=1, debug_req_i=10 and debug_mode_i rising 10 then 11: debug_req_o SHALL be 11, then 01, then 00, and halt_done_o SHALL pulse when debug_mode_i=11.
REQ-034 With TimeoutCycles=8 and no acknowledge: timeout_o SHALL pulse exactly 8 cycles after WAIT_ACK entry and debug_req_o SHALL be 0 afterward.
REQ-035 With hart_unavailable_i=10 and group_en_i=1: mask SHALL be 01, and debug_req_i=10 alone SHALL be ignored.
REQ-036 Driving debug_ndmreset_ni low mid-WAIT_ACK SHALL zero debug_req_o on the next cycle, force IDLE and produce no pulses.
REQ-037 When the final acknowledge arrives in the timeout cycle: halt_done_o SHALL be 1 and timeout_o SHALL be 0.
